fanout_broadcast: RTL and testbench

- Registered eager fork: takes one upstream ready/valid stream and broadcasts each token to up to NUM_OUT downstream branches.
- Each branch is gated by a static enable and by a per-token route mask.
- Each branch completes its handshake on its own; the upstream slot frees once every routed, enabled branch has accepted.
- This is the forward (valid-driving) side that pairs with the combinational fanout ready-aggregation logic in the sparse-stream interconnect.

---
 rtl/fanout_broadcast.sv | 91 +++++++++
 tb/tb_fanout_broadcast.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fanout_broadcast.sv
// Registered eager fork: holds one upstream token and offers it to every
// routed, enabled branch; each branch handshakes independently and the slot
// frees (or is refilled the same cycle) once all owed branches have taken it.

// Per-branch valid/owed logic for the held token.
module fanout_branch (
  input  logic full,
  input  logic pend,
  input  logic en,
  input  logic ready,
  output logic valid,
  output logic left
);
  // A disabled branch stops being owed at once; a taken branch is cleared.
  always_comb begin
    valid = full & pend & en;
    left  = pend & en & ~(valid & ready);
  end
endmodule

module fanout_broadcast #(
  parameter int NUM_OUT    = 7,
  parameter int DATA_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_OUT-1:0]    en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [NUM_OUT-1:0]    in_route,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready
);

  logic                  full;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_OUT-1:0]    pend;
  logic [NUM_OUT-1:0]    left;
  logic [NUM_OUT-1:0]    m;
  logic                  drain;
  logic                  cap;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_br
      fanout_branch u_br (
        .full  (full),
        .pend  (pend[gi]),
        .en    (en[gi]),
        .ready (out_ready[gi]),
        .valid (out_valid[gi]),
        .left  (left[gi])
      );
    end
  endgenerate

  // Slot frees this cycle when nobody is still owed; refill with no bubble.
  // in_ready is held low during reset and during a flush cycle.
  always_comb begin
    drain    = full & ~(|left);
    in_ready = rst_n & ~flush & (~full | drain);
    cap      = in_valid & in_ready;
    m        = in_route & en;
    out_data = data_q;
  end

  // Token slot: flush beats capture; a token routed nowhere is swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      pend   <= '0;
      data_q <= '0;
    end else if (flush) begin
      full <= 1'b0;
      pend <= '0;
    end else if (cap) begin
      data_q <= in_data;
      full   <= |m;
      pend   <= m;
    end else if (drain) begin
      full <= 1'b0;
      pend <= '0;
    end else begin
      pend <= left;
    end
  end

endmodule

// File: tb/tb_fanout_broadcast.sv
// Directed bench for fanout_broadcast: inputs change on the falling edge,
// outputs are checked 1ns later, well clear of the rising (active) edge.
module tb_fanout_broadcast;
  localparam int N  = 7;
  localparam int DW = 17;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [N-1:0]  en;
  logic [DW-1:0] in_data;
  logic [N-1:0]  in_route;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;

  int checks   = 0;
  int failures = 0;

  fanout_broadcast #(.NUM_OUT(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .en        (en),
    .in_data   (in_data),
    .in_route  (in_route),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; en = 7'h7F; in_data = '0; in_route = '0;
    in_valid = 1'b0; out_ready = 7'h7F;

    // Reset state
    #3;
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_od", 32'(out_data), 32'h0);
    chk("rst_ir", 32'(in_ready), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("rel_ir", 32'(in_ready), 32'h1);

    // 1: broadcast to all, 4-token back-to-back stream
    tick();
    in_valid = 1'b1; in_route = 7'h7F; in_data = 17'h000A5;
    #1 chk("t1_ir0", 32'(in_ready), 32'h1);
    tick(); in_data = 17'h000B1;
    #1 chk("t1_ov0", 32'(out_valid), 32'h7F);
    chk("t1_od0", 32'(out_data), 32'h000A5);
    chk("t1_ir1", 32'(in_ready), 32'h1);
    tick(); in_data = 17'h000B2;
    #1 chk("t1_od1", 32'(out_data), 32'h000B1);
    chk("t1_ir2", 32'(in_ready), 32'h1);
    tick(); in_data = 17'h000B3;
    #1 chk("t1_od2", 32'(out_data), 32'h000B2);
    chk("t1_ir3", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    #1 chk("t1_od3", 32'(out_data), 32'h000B3);
    chk("t1_ov3", 32'(out_valid), 32'h7F);
    tick();
    #1 chk("t1_idle", 32'(out_valid), 32'h0);

    // 2: route {0,2}, branch 2 stalls
    out_ready = 7'b1111011; in_valid = 1'b1; in_route = 7'b0000101; in_data = 17'h000C2;
    tick(); in_valid = 1'b0;
    #1 chk("t2_ov0", 32'(out_valid), 32'h05);
    chk("t2_ir0", 32'(in_ready), 32'h0);
    tick();
    #1 chk("t2_ov1", 32'(out_valid), 32'h04);
    chk("t2_ir1", 32'(in_ready), 32'h0);
    tick();
    #1 chk("t2_ov2", 32'(out_valid), 32'h04);
    out_ready = 7'h7F;
    #1 chk("t2_ir2", 32'(in_ready), 32'h1);
    tick();
    #1 chk("t2_ov3", 32'(out_valid), 32'h0);

    // 3: token routed only to disabled branches is dropped
    en = 7'b0000011; in_valid = 1'b1; in_route = 7'b1111100; in_data = 17'h000D3;
    #1 chk("t3_ir0", 32'(in_ready), 32'h1);
    tick(); in_data = 17'h000D4;
    #1 chk("t3_ov0", 32'(out_valid), 32'h0);
    chk("t3_ir1", 32'(in_ready), 32'h1);
    chk("t3_od0", 32'(out_data), 32'h000D3);
    tick(); in_valid = 1'b0;
    #1 chk("t3_ov1", 32'(out_valid), 32'h0);
    chk("t3_ir2", 32'(in_ready), 32'h1);
    en = 7'h7F;

    // 4: pend {1,3}; branch 1 taken, then en[3] dropped while stalled
    out_ready = 7'b1110111; in_valid = 1'b1; in_route = 7'b0001010; in_data = 17'h000E4;
    tick(); in_valid = 1'b0;
    #1 chk("t4_ov0", 32'(out_valid), 32'h0A);
    chk("t4_ir0", 32'(in_ready), 32'h0);
    tick();
    #1 chk("t4_ov1", 32'(out_valid), 32'h08);
    en = 7'b1110111;
    #1 chk("t4_ir1", 32'(in_ready), 32'h1);
    chk("t4_ov2", 32'(out_valid), 32'h0);
    tick();
    en = 7'h7F;
    #1 chk("t4_norejoin", 32'(out_valid), 32'h0);
    chk("t4_ir2", 32'(in_ready), 32'h1);

    // 5: flush while holding a token for branch 6
    out_ready = 7'h3F; in_valid = 1'b1; in_route = 7'b1000000; in_data = 17'h000F5;
    tick(); in_valid = 1'b0;
    #1 chk("t5_ov0", 32'(out_valid), 32'h40);
    flush = 1'b1; in_valid = 1'b1; in_route = 7'b0000001; in_data = 17'h000F6;
    #1 chk("t5_irf", 32'(in_ready), 32'h0);
    tick(); flush = 1'b0;
    #1 chk("t5_ov1", 32'(out_valid), 32'h0);
    chk("t5_ir1", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    #1 chk("t5_ov2", 32'(out_valid), 32'h01);
    chk("t5_od2", 32'(out_data), 32'h000F6);
    tick();
    #1 chk("t5_ov3", 32'(out_valid), 32'h0);

    // 6: asynchronous reset mid-hold, released off the clock edge
    out_ready = 7'h00; in_valid = 1'b1; in_route = 7'b0000010; in_data = 17'h00A7;
    tick(); in_valid = 1'b0;
    #1 chk("t6_ov0", 32'(out_valid), 32'h02);
    #2 rst_n = 1'b0;
    #1 chk("t6_ovr", 32'(out_valid), 32'h0);
    chk("t6_irr", 32'(in_ready), 32'h0);
    chk("t6_odr", 32'(out_data), 32'h0);
    #3 rst_n = 1'b1;
    tick();
    #1 chk("t6_ir1", 32'(in_ready), 32'h1);
    chk("t6_ov1", 32'(out_valid), 32'h0);
    out_ready = 7'h7F;
    tick();
    #1 chk("t6_ov2", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
